// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, small-sigma functions and the
// message-schedule state encoding.
package sha256_pkg;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428A2F98, 32'h71374491, 32'hB5C0FBCF, 32'hE9B5DBA5,
        32'h3956C25B, 32'h59F111F1, 32'h923F82A4, 32'hAB1C5ED5,
        32'hD807AA98, 32'h12835B01, 32'h243185BE, 32'h550C7DC3,
        32'h72BE5D74, 32'h80DEB1FE, 32'h9BDC06A7, 32'hC19BF174,
        32'hE49B69C1, 32'hEFBE4786, 32'h0FC19DC6, 32'h240CA1CC,
        32'h2DE92C6F, 32'h4A7484AA, 32'h5CB0A9DC, 32'h76F988DA,
        32'h983E5152, 32'hA831C66D, 32'hB00327C8, 32'hBF597FC7,
        32'hC6E00BF3, 32'hD5A79147, 32'h06CA6351, 32'h14292967,
        32'h27B70A85, 32'h2E1B2138, 32'h4D2C6DFC, 32'h53380D13,
        32'h650A7354, 32'h766A0ABB, 32'h81C2C92E, 32'h92722C85,
        32'hA2BFE8A1, 32'hA81A664B, 32'hC24B8B70, 32'hC76C51A3,
        32'hD192E819, 32'hD6990624, 32'hF40E3585, 32'h106AA070,
        32'h19A4C116, 32'h1E376C08, 32'h2748774C, 32'h34B0BCB5,
        32'h391C0CB3, 32'h4ED8AA4A, 32'h5B9CCA4F, 32'h682E6FF3,
        32'h748F82EE, 32'h78A5636F, 32'h84C87814, 32'h8CC70208,
        32'h90BEFFFA, 32'hA4506CEB, 32'hBEF9A3F7, 32'hC67178F2
    };

    // ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup, indexed by round number.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  i_idx,
    output logic [31:0] o_k
);

    assign o_k = K_TABLE[i_idx];

endmodule

// File: rtl/message_schedule.sv
// SHA-256 message schedule: loads a 16-word block, then streams W[t], K[t] and t
// for t = 0..63 using a 16-entry circular buffer that is overwritten in place.
module message_schedule
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        blk_valid,
    output logic        blk_ready,
    input  logic [31:0] blk_word,
    output logic        sched_valid,
    input  logic        sched_ready,
    output logic [31:0] sched_word,
    output logic [31:0] sched_const,
    output logic [5:0]  sched_round,
    output logic        sched_last
);

    sched_state_e r_state;
    sched_state_e w_state_nxt;

    logic [3:0]  r_cnt;
    logic [5:0]  r_round;
    logic [31:0] r_buf [16];
    logic [31:0] r_word;
    logic [31:0] r_const;
    logic        r_valid;
    logic        r_last;

    logic        w_load_fire;
    logic        w_last_word;
    logic        w_run_fire;
    logic        w_advance;
    logic        w_finish;
    logic [5:0]  w_t_next;
    logic [3:0]  w_slot;
    logic [3:0]  w_i1;
    logic [3:0]  w_i6;
    logic [3:0]  w_i14;
    logic [5:0]  w_k_idx;
    logic [31:0] w_k;
    logic [31:0] w_expand;
    logic [31:0] w_next_word;

    assign w_load_fire = (r_state == ST_LOAD) && blk_valid;
    assign w_last_word = w_load_fire && (r_cnt == 4'd15);
    assign w_run_fire  = (r_state == ST_RUN) && sched_ready;
    assign w_advance   = w_run_fire && (r_round != 6'd63);
    assign w_finish    = w_run_fire && (r_round == 6'd63);

    // Slot (t+1)&15 still holds W[t-15] here; it is consumed and replaced by W[t+1].
    assign w_t_next = r_round + 6'd1;
    assign w_slot   = w_t_next[3:0];
    assign w_i1     = r_round[3:0] - 4'd1;
    assign w_i6     = r_round[3:0] - 4'd6;
    assign w_i14    = r_round[3:0] - 4'd14;
    assign w_expand = sigma1(r_buf[w_i1]) + r_buf[w_i6] + sigma0(r_buf[w_i14]) + r_buf[w_slot];
    assign w_k_idx  = (r_state == ST_LOAD) ? 6'd0 : w_t_next;

    sha256_k_rom u_k_rom (
        .i_idx (w_k_idx),
        .o_k   (w_k)
    );

    // Next scheduled word: raw message word for the first 16 rounds, expansion after.
    always_comb begin
        w_next_word = w_expand;
        if (w_t_next < 6'd16) begin
            w_next_word = r_buf[w_slot];
        end else begin
            w_next_word = w_expand;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_last_word) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (w_finish) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // Word buffer: filled during load, rewritten in place from round 16 onward.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_buf[r_cnt] <= blk_word;
        end else if (w_advance && (w_t_next >= 6'd16)) begin
            r_buf[w_slot] <= w_expand;
        end
    end

    // Load counter, round counter and registered schedule outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_round <= 6'd0;
            r_word  <= 32'd0;
            r_const <= 32'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_load_fire) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_last_word) begin
                r_word  <= r_buf[0];
                r_const <= w_k;
                r_round <= 6'd0;
                r_valid <= 1'b1;
                r_last  <= 1'b0;
            end else if (w_advance) begin
                r_word  <= w_next_word;
                r_const <= w_k;
                r_round <= w_t_next;
                r_last  <= (w_t_next == 6'd63);
            end else if (w_finish) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_round <= 6'd0;
                r_cnt   <= 4'd0;
            end
        end
    end

    assign blk_ready   = (r_state == ST_LOAD);
    assign sched_valid = r_valid;
    assign sched_word  = r_word;
    assign sched_const = r_const;
    assign sched_round = r_round;
    assign sched_last  = r_last;

endmodule

// File: tb/tb_message_schedule.sv
// Randomized self-checking bench for message_schedule against a plain
// SHA-256 schedule model.
module tb_message_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] blk_word;
    logic        sched_valid;
    logic        sched_ready;
    logic [31:0] sched_word;
    logic [31:0] sched_const;
    logic [5:0]  sched_round;
    logic        sched_last;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [31:0] g_msg [16];
    logic [31:0] g_w   [64];

    localparam logic [31:0] K_REF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] ABC_GOLD [3] = '{32'h61626380, 32'h000F0000, 32'h7DA86405};

    message_schedule dut (
        .clk         (clk),
        .rst         (rst),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .blk_word    (blk_word),
        .sched_valid (sched_valid),
        .sched_ready (sched_ready),
        .sched_word  (sched_word),
        .sched_const (sched_const),
        .sched_round (sched_round),
        .sched_last  (sched_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_model();
        logic [31:0] s0;
        logic [31:0] s1;
        for (int i = 0; i < 16; i++) g_w[i] = g_msg[i];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(g_w[t-15], 7) ^ rotr(g_w[t-15], 18) ^ (g_w[t-15] >> 3);
            s1 = rotr(g_w[t-2], 17) ^ rotr(g_w[t-2], 19) ^ (g_w[t-2] >> 10);
            g_w[t] = s1 + g_w[t-7] + s0 + g_w[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) g_msg[i] = 32'h0;
        g_msg[0]  = 32'h61626380;
        g_msg[15] = 32'h00000018;
        build_model();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) g_msg[i] = $urandom;
        build_model();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                blk_valid = 1'b0;
                blk_word  = $urandom;
                tick();
            end
            check("load_ready", {31'd0, blk_ready}, 32'd1);
            check("load_idle", {31'd0, sched_valid}, 32'd0);
            blk_valid = 1'b1;
            blk_word  = g_msg[i];
            tick();
        end
        blk_valid = 1'b0;
        check("first_valid", {31'd0, sched_valid}, 32'd1);
    endtask

    // Streams rounds until 64 are consumed or stop_at is reached.
    task automatic stream(input int ready_pct, input int stall_at, input int stop_at, input bit abc);
        int t = 0;
        int budget = 2000;
        int stall = 0;
        while (t < 64 && t != stop_at) begin
            if (budget == 0) begin
                check("stream_timeout", t, 32'd64);
                break;
            end
            budget--;
            check("run_valid", {31'd0, sched_valid}, 32'd1);
            check("run_word", sched_word, g_w[t]);
            check("run_const", sched_const, K_REF[t]);
            check("run_round", {26'd0, sched_round}, t);
            check("run_last", {31'd0, sched_last}, (t == 63) ? 32'd1 : 32'd0);
            check("run_blk_ready", {31'd0, blk_ready}, 32'd0);
            if (abc && t >= 16 && t <= 18) check("abc_golden", sched_word, ABC_GOLD[t-16]);
            if (t == stall_at && stall < 5) begin
                sched_ready = 1'b0;
                stall++;
            end else begin
                sched_ready = ($urandom_range(99) < ready_pct);
            end
            blk_valid = $urandom_range(1);
            blk_word  = $urandom;
            tick();
            blk_valid = 1'b0;
            if (sched_ready) t++;
        end
        sched_ready = 1'b1;
        if (t == 64) begin
            check("end_valid", {31'd0, sched_valid}, 32'd0);
            check("end_last", {31'd0, sched_last}, 32'd0);
            check("end_blk_ready", {31'd0, blk_ready}, 32'd1);
        end
    endtask

    initial begin
        rst         = 1'b1;
        blk_valid   = 1'b0;
        blk_word    = 32'd0;
        sched_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'd0, sched_valid}, 32'd0);
        check("rst_blk_ready", {31'd0, blk_ready}, 32'd1);
        check("rst_word", sched_word, 32'd0);
        check("rst_const", sched_const, 32'd0);
        check("rst_round", {26'd0, sched_round}, 32'd0);
        check("rst_last", {31'd0, sched_last}, 32'd0);
        rst = 1'b0;

        set_abc();
        load_block(1'b0);
        stream(100, -1, -1, 1'b1);

        // Back-to-back block with a five-cycle stall at round 20
        load_block(1'b0);
        stream(100, 20, -1, 1'b1);

        set_random();
        load_block(1'b1);
        stream(100, -1, -1, 1'b0);

        // Reset in the middle of a run, then a fresh block
        set_abc();
        load_block(1'b0);
        stream(100, -1, 30, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", {31'd0, sched_valid}, 32'd0);
        check("midrst_blk_ready", {31'd0, blk_ready}, 32'd1);
        load_block(1'b0);
        stream(100, -1, -1, 1'b1);

        // Partial load discarded by reset
        set_random();
        blk_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            blk_word = $urandom;
            tick();
        end
        blk_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_block(1'b0);
        stream(100, -1, -1, 1'b0);

        for (int b = 0; b < 400; b++) begin
            set_random();
            load_block($urandom_range(1));
            stream(70, -1, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
